// File: rtl/ppu_pixel_mux_pkg.sv
// Shared types, widths, NES colour table and palette address mirroring for the pixel mux.
package ppu_pixel_mux_pkg;

    localparam int unsigned PAL_ADDR_W  = 5;
    localparam int unsigned PAL_DATA_W  = 6;
    localparam int unsigned PAL_DEPTH   = 32;
    localparam int unsigned RGB_W       = 24;
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned NES_COLOURS = 64;

    typedef logic [PAL_ADDR_W-1:0] pal_addr_t;
    typedef logic [PAL_DATA_W-1:0] pal_data_t;
    typedef logic [RGB_W-1:0]      rgb_t;
    typedef logic [COORD_W-1:0]    coord_t;

    // Greyscale keeps only the luma row of the colour index.
    localparam pal_data_t GREY_MASK = 6'h30;

    // Control that travels alongside the palette read through stage 1.
    typedef struct packed {
        logic visible;
        logic greyscale;
    } stage1_t;

    // 2C02 colour index -> 24-bit {R,G,B}.
    localparam rgb_t NES_RGB [NES_COLOURS] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    // Sprite backdrop entries $10/$14/$18/$1C alias the BG entries $00/$04/$08/$0C.
    function automatic pal_addr_t mirror_pal_addr(input pal_addr_t addr);
        pal_addr_t res;
        res = addr;
        if (addr[4] && (addr[1:0] == 2'b00)) begin
            res[4] = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/ppu_pixel_mux_if.sv
// Pixel/CPU-palette bus between the fetch stages, CPU decode and the pixel mux.
interface ppu_pixel_mux_if;
    import ppu_pixel_mux_pkg::*;

    coord_t    x_idx;
    coord_t    scanline;
    logic [4:0] bg_pixel;
    logic [4:0] spr_pixel;
    logic      spr_priority;
    logic      spr_is_zero;
    logic      show_bg;
    logic      show_spr;
    logic      show_bg_l8;
    logic      show_spr_l8;
    logic      greyscale;
    logic      pal_we;
    pal_addr_t pal_addr;
    pal_data_t pal_wdata;
    pal_data_t pal_rdata;
    logic      sprite0_hit;
    rgb_t      rgb;
    logic      rgb_valid;

    modport master (
        output x_idx, scanline, bg_pixel, spr_pixel, spr_priority, spr_is_zero,
               show_bg, show_spr, show_bg_l8, show_spr_l8, greyscale,
               pal_we, pal_addr, pal_wdata,
        input  pal_rdata, sprite0_hit, rgb, rgb_valid
    );

    modport slave (
        input  x_idx, scanline, bg_pixel, spr_pixel, spr_priority, spr_is_zero,
               show_bg, show_spr, show_bg_l8, show_spr_l8, greyscale,
               pal_we, pal_addr, pal_wdata,
        output pal_rdata, sprite0_hit, rgb, rgb_valid
    );

endinterface

// File: rtl/ppu_pixel_mux_palette_ram.sv
// 32x6 palette RAM: CPU read/write port plus render read port, both with registered reads.
module ppu_pixel_mux_palette_ram
    import ppu_pixel_mux_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      we,
    input  pal_addr_t cpu_addr,
    input  pal_data_t wdata,
    input  pal_addr_t render_addr,
    output pal_data_t cpu_rdata,
    output pal_data_t render_rdata
);

    pal_data_t mem [PAL_DEPTH];
    pal_addr_t cpu_addr_m_c;
    pal_addr_t render_addr_m_c;

    assign cpu_addr_m_c    = mirror_pal_addr(cpu_addr);
    assign render_addr_m_c = mirror_pal_addr(render_addr);

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[cpu_addr_m_c] <= wdata;
        end
    end

    // Read registers: CPU port sees its own write, render port sees the pre-write value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata    <= '0;
            render_rdata <= '0;
        end else begin
            cpu_rdata    <= we ? wdata : mem[cpu_addr_m_c];
            render_rdata <= mem[render_addr_m_c];
        end
    end

endmodule

// File: rtl/ppu_pixel_mux.sv
// Per-dot BG/sprite merge, sprite-0 hit flag and palette/colour lookup to 24-bit RGB.
module ppu_pixel_mux
    import ppu_pixel_mux_pkg::*;
#(
    parameter int unsigned PRERENDER_LINE = 0,
    parameter int unsigned FIRST_VIS_LINE = 1
) (
    input  logic           clk,
    input  logic           reset,
    ppu_pixel_mux_if.slave bus
);

    logic       visible_c;
    logic       bg_on_c;
    logic       spr_on_c;
    logic [3:0] bg_c;
    logic [3:0] spr_c;
    logic       bg_opaque_c;
    logic       spr_opaque_c;
    pal_addr_t  render_addr_c;
    logic       hit_set_c;
    logic       hit_clr_c;
    pal_data_t  render_data;
    pal_data_t  cpu_rdata;
    pal_data_t  lut_idx_c;
    stage1_t    s1;

    assign visible_c = (bus.x_idx < 10'd256)
                    && (bus.scanline >= COORD_W'(FIRST_VIS_LINE))
                    && (bus.scanline <= COORD_W'(FIRST_VIS_LINE + 239));

    assign bg_on_c      = bus.show_bg  && ((bus.x_idx >= 10'd8) || bus.show_bg_l8);
    assign spr_on_c     = bus.show_spr && ((bus.x_idx >= 10'd8) || bus.show_spr_l8);
    assign bg_c         = bg_on_c  ? bus.bg_pixel[3:0]  : 4'h0;
    assign spr_c        = spr_on_c ? bus.spr_pixel[3:0] : 4'h0;
    assign bg_opaque_c  = (bg_c[1:0]  != 2'b00);
    assign spr_opaque_c = (spr_c[1:0] != 2'b00);

    // BG/sprite priority resolution into a palette address.
    always_comb begin
        render_addr_c = 5'h00;
        if (bg_opaque_c && spr_opaque_c) begin
            render_addr_c = bus.spr_priority ? {1'b0, bg_c} : {1'b1, spr_c};
        end else if (bg_opaque_c) begin
            render_addr_c = {1'b0, bg_c};
        end else if (spr_opaque_c) begin
            render_addr_c = {1'b1, spr_c};
        end
    end

    // Hit uses the raw pixels gated by clipping; sprite priority does not matter.
    assign hit_set_c = visible_c && (bus.x_idx != 10'd255) && bg_on_c && spr_on_c
                    && bus.spr_is_zero && (bus.bg_pixel[1:0] != 2'b00)
                    && (bus.spr_pixel[1:0] != 2'b00);
    assign hit_clr_c = (bus.scanline == COORD_W'(PRERENDER_LINE)) && (bus.x_idx == 10'd1);

    ppu_pixel_mux_palette_ram u_pal_ram (
        .clk          (clk),
        .reset        (reset),
        .we           (bus.pal_we),
        .cpu_addr     (bus.pal_addr),
        .wdata        (bus.pal_wdata),
        .render_addr  (render_addr_c),
        .cpu_rdata    (cpu_rdata),
        .render_rdata (render_data)
    );

    assign bus.pal_rdata = cpu_rdata;
    assign lut_idx_c     = s1.greyscale ? (render_data & GREY_MASK) : render_data;

    // Stage 1 control, aligned with the registered palette read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
        end else begin
            s1 <= '{visible: visible_c, greyscale: bus.greyscale};
        end
    end

    // Stage 2: colour LUT, blanked outside the visible area.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rgb       <= '0;
            bus.rgb_valid <= 1'b0;
        end else begin
            bus.rgb       <= s1.visible ? NES_RGB[lut_idx_c] : '0;
            bus.rgb_valid <= s1.visible;
        end
    end

    // Sticky sprite-0 hit; the pre-render clear beats a same-cycle set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.sprite0_hit <= 1'b0;
        end else if (hit_clr_c) begin
            bus.sprite0_hit <= 1'b0;
        end else if (hit_set_c) begin
            bus.sprite0_hit <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ppu_pixel_mux.sv
// Self-checking bench for ppu_pixel_mux: rgb scoreboard plus per-feature inline checks.
module tb_ppu_pixel_mux;
    import ppu_pixel_mux_pkg::*;

    typedef struct {
        logic [23:0] rgb;
        logic        valid;
    } exp_t;

    logic clk;
    logic reset;
    int   vectors;
    int   errors;
    exp_t sb [$];
    logic [5:0] model [32];

    ppu_pixel_mux_if bus ();

    ppu_pixel_mux dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push the expected result of the current dot, clock it, and retire the dot issued two cycles ago.
    task automatic tick_push();
        exp_t e;
        logic vis, bon, son;
        logic [3:0] b, s;
        logic [4:0] a, wa;
        logic [5:0] p;
        vis = (bus.x_idx < 10'd256) && (bus.scanline >= 10'd1) && (bus.scanline <= 10'd240);
        bon = bus.show_bg  && (bus.x_idx >= 10'd8 || bus.show_bg_l8);
        son = bus.show_spr && (bus.x_idx >= 10'd8 || bus.show_spr_l8);
        b = bon ? bus.bg_pixel[3:0]  : 4'h0;
        s = son ? bus.spr_pixel[3:0] : 4'h0;
        if (s[1:0] != 2'b00 && (b[1:0] == 2'b00 || !bus.spr_priority)) a = {1'b1, s};
        else if (b[1:0] != 2'b00) a = {1'b0, b};
        else a = 5'h00;
        if (a[4] && a[1:0] == 2'b00) a[4] = 1'b0;
        p = model[a];
        if (bus.greyscale) p = {p[5:4], 4'h0};
        e.rgb   = vis ? NES_RGB[p] : 24'h0;
        e.valid = vis;
        sb.push_back(e);
        if (bus.pal_we) begin
            wa = bus.pal_addr;
            if (wa[4] && wa[1:0] == 2'b00) wa[4] = 1'b0;
            model[wa] = bus.pal_wdata;
        end
        @(posedge clk);
        #1;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            vectors++;
            if (bus.rgb !== e.rgb || bus.rgb_valid !== e.valid) begin
                errors++;
                $display("FAIL rgb_pipe: got rgb=%h valid=%b, expected rgb=%h valid=%b",
                         bus.rgb, bus.rgb_valid, e.rgb, e.valid);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        bus.x_idx  = 10'd300;
        bus.pal_we = 1'b0;
        for (int i = 0; i < n; i++) tick_push();
    endtask

    task automatic write_pal(input logic [4:0] addr, input logic [5:0] data);
        bus.pal_we    = 1'b1;
        bus.pal_addr  = addr;
        bus.pal_wdata = data;
        tick_push();
        bus.pal_we    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.rgb !== 24'h0 || bus.rgb_valid !== 1'b0 || bus.sprite0_hit !== 1'b0 || bus.pal_rdata !== 6'h0) begin
            errors++;
            $display("FAIL reset_state: rgb=%h valid=%b hit=%b rdata=%h, expected all zero",
                     bus.rgb, bus.rgb_valid, bus.sprite0_hit, bus.pal_rdata);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_palette_load();
        idle(1);
        for (int i = 0; i < 32; i++) write_pal(5'(i), 6'((i * 5 + 3) % 64));
        write_pal(5'h00, 6'h0F);
        write_pal(5'h01, 6'h30);
        write_pal(5'h05, 6'h2A);
        write_pal(5'h11, 6'h16);
        bus.pal_addr = 5'h01;
        tick_push();
        vectors++;
        if (bus.pal_rdata !== 6'h30) begin
            errors++;
            $display("FAIL pal_read_01: got %h expected 30", bus.pal_rdata);
        end
    endtask

    task automatic test_bg_only();
        bus.scanline = 10'd10;
        bus.x_idx = 10'd20;
        bus.show_bg = 1'b1; bus.show_spr = 1'b1;
        bus.show_bg_l8 = 1'b1; bus.show_spr_l8 = 1'b1;
        bus.bg_pixel = 5'h01; bus.spr_pixel = 5'h10;
        tick_push();
        bus.x_idx = 10'd300;
        tick_push();
        vectors++;
        if (bus.rgb !== 24'hFCFCFC || bus.rgb_valid !== 1'b1) begin
            errors++;
            $display("FAIL bg_only_latency: got rgb=%h valid=%b expected FCFCFC 1", bus.rgb, bus.rgb_valid);
        end
        idle(1);
    endtask

    task automatic test_priority();
        bus.scanline = 10'd30;
        bus.spr_is_zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.x_idx = 10'(40 + i);
            bus.bg_pixel = (i < 2) ? 5'h01 : 5'h00;
            bus.spr_pixel = 5'h11;
            bus.spr_priority = i[0];
            tick_push();
        end
        bus.spr_priority = 1'b0;
        idle(2);
    endtask

    task automatic test_mirror();
        write_pal(5'h10, 6'h21);
        bus.pal_addr = 5'h00;
        tick_push();
        vectors++;
        if (bus.pal_rdata !== 6'h21) begin
            errors++;
            $display("FAIL mirror_10_00: got %h expected 21", bus.pal_rdata);
        end
        write_pal(5'h14, 6'h05);
        bus.pal_addr = 5'h04;
        tick_push();
        vectors++;
        if (bus.pal_rdata !== 6'h05) begin
            errors++;
            $display("FAIL mirror_14_04: got %h expected 05", bus.pal_rdata);
        end
        write_pal(5'h07, 6'h1A);
        vectors++;
        if (bus.pal_rdata !== 6'h1A) begin
            errors++;
            $display("FAIL write_bypass: got %h expected 1a", bus.pal_rdata);
        end
        // Transparent dot now renders through the aliased backdrop entry.
        bus.scanline = 10'd20; bus.x_idx = 10'd50;
        bus.bg_pixel = 5'h00; bus.spr_pixel = 5'h10;
        tick_push();
        idle(2);
    endtask

    task automatic test_sprite0();
        bus.scanline = 10'd50;
        bus.show_bg_l8 = 1'b0; bus.show_spr_l8 = 1'b1;
        bus.bg_pixel = 5'h01; bus.spr_pixel = 5'h11; bus.spr_is_zero = 1'b1;
        bus.x_idx = 10'd5;
        tick_push();
        vectors++;
        if (bus.sprite0_hit !== 1'b0) begin
            errors++; $display("FAIL hit_clip_l8: got %b expected 0", bus.sprite0_hit);
        end
        bus.x_idx = 10'd255;
        tick_push();
        vectors++;
        if (bus.sprite0_hit !== 1'b0) begin
            errors++; $display("FAIL hit_x255: got %b expected 0", bus.sprite0_hit);
        end
        bus.x_idx = 10'd100;
        tick_push();
        vectors++;
        if (bus.sprite0_hit !== 1'b1) begin
            errors++; $display("FAIL hit_set: got %b expected 1", bus.sprite0_hit);
        end
        bus.spr_is_zero = 1'b0;
        bus.scanline = 10'd240; bus.x_idx = 10'd10;
        tick_push();
        bus.scanline = 10'd0; bus.x_idx = 10'd0;
        tick_push();
        vectors++;
        if (bus.sprite0_hit !== 1'b1) begin
            errors++; $display("FAIL hit_hold: got %b expected 1", bus.sprite0_hit);
        end
        bus.x_idx = 10'd1;
        tick_push();
        vectors++;
        if (bus.sprite0_hit !== 1'b0) begin
            errors++; $display("FAIL hit_clear: got %b expected 0", bus.sprite0_hit);
        end
        bus.show_bg_l8 = 1'b1;
        idle(2);
    endtask

    task automatic test_greyscale();
        bus.scanline = 10'd60; bus.x_idx = 10'd30;
        bus.bg_pixel = 5'h05; bus.spr_pixel = 5'h10;
        bus.greyscale = 1'b1;
        tick_push();
        bus.x_idx = 10'd300;
        tick_push();
        vectors++;
        if (bus.rgb !== 24'hF8F8F8) begin
            errors++; $display("FAIL greyscale: got %h expected f8f8f8", bus.rgb);
        end
        tick_push();
        vectors++;
        if (bus.rgb !== 24'h0 || bus.rgb_valid !== 1'b0) begin
            errors++; $display("FAIL offscreen: got rgb=%h valid=%b expected 0 0", bus.rgb, bus.rgb_valid);
        end
        bus.greyscale = 1'b0;
        idle(1);
    endtask

    task automatic test_back_to_back();
        bus.spr_is_zero = 1'b0;
        for (int i = 0; i < 24; i++) begin
            bus.x_idx        = 10'($urandom_range(0, 299));
            bus.scanline     = 10'($urandom_range(0, 250));
            bus.bg_pixel     = {1'b0, 4'($urandom_range(0, 15))};
            bus.spr_pixel    = {1'b1, 4'($urandom_range(0, 15))};
            bus.spr_priority = 1'($urandom_range(0, 1));
            bus.show_bg      = 1'($urandom_range(0, 1));
            bus.show_spr     = 1'($urandom_range(0, 1));
            bus.show_bg_l8   = 1'($urandom_range(0, 1));
            bus.show_spr_l8  = 1'($urandom_range(0, 1));
            bus.greyscale    = 1'($urandom_range(0, 1));
            tick_push();
        end
        bus.show_bg = 1'b1; bus.show_spr = 1'b1;
        bus.show_bg_l8 = 1'b1; bus.show_spr_l8 = 1'b1;
        bus.greyscale = 1'b0;
        idle(2);
    endtask

    task automatic test_reset_midframe();
        bus.scanline = 10'd70; bus.x_idx = 10'd100;
        bus.bg_pixel = 5'h01; bus.spr_pixel = 5'h11; bus.spr_is_zero = 1'b1;
        bus.spr_priority = 1'b0;
        tick_push();
        bus.spr_is_zero = 1'b0; bus.x_idx = 10'd101;
        tick_push();
        vectors++;
        if (bus.sprite0_hit !== 1'b1 || bus.rgb_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got hit=%b valid=%b expected 1 1", bus.sprite0_hit, bus.rgb_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.rgb !== 24'h0 || bus.rgb_valid !== 1'b0 || bus.sprite0_hit !== 1'b0 || bus.pal_rdata !== 6'h0) begin
            errors++;
            $display("FAIL async_reset: rgb=%h valid=%b hit=%b rdata=%h expected all zero",
                     bus.rgb, bus.rgb_valid, bus.sprite0_hit, bus.pal_rdata);
        end
        sb.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        bus.x_idx = 10'd120;
        tick_push();
        idle(2);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        bus.x_idx = 10'd300; bus.scanline = 10'd0;
        bus.bg_pixel = 5'h00; bus.spr_pixel = 5'h10;
        bus.spr_priority = 1'b0; bus.spr_is_zero = 1'b0;
        bus.show_bg = 1'b0; bus.show_spr = 1'b0;
        bus.show_bg_l8 = 1'b0; bus.show_spr_l8 = 1'b0;
        bus.greyscale = 1'b0;
        bus.pal_we = 1'b0; bus.pal_addr = 5'h00; bus.pal_wdata = 6'h00;
        test_reset();
        test_palette_load();
        test_bg_only();
        test_priority();
        test_mirror();
        test_sprite0();
        test_greyscale();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
